spm_lsu: RTL and testbench

MEM-stage load/store initiator that drives the data port of the dual-port scratchpad memory (SPM). It accepts one load or store request at a time from the pipeline. Byte and halfword loads are extracted and sign/zero-extended from a full-word read. Byte and halfword stores are performed as read-modify-write, because the SPM writes only whole words.

---
 rtl/spm_lsu.sv | 197 +++++++++++++++++++
 tb/tb_spm_lsu.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spm_lsu.sv
// spm_lsu -- MEM-stage load/store initiator for the SPM data port.
//
// Accepts one load/store at a time. Sub-word loads are extracted from a full
// word read and sign/zero-extended; sub-word stores are read-modify-write
// because the SPM only writes whole words. Byte lanes are big-endian:
// byte offset o lives in word bits [31-8o:24-8o].
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req/ready           request strobe, accepted only while ready=1 (IDLE)
//   we/size/uns/addr/wdata  request fields (size 00 byte, 01 half, 1x word)
//   rdata/done/err      registered response, valid while done=1
//   spm_addr/spm_as_/spm_rw/spm_wr_data/spm_rd_data  SPM data port
//
// Configuration macro: SPM_LSU_MISALIGN_CHK_EN
//   defined   : misaligned half/word requests complete with err=1, no SPM access
//   undefined : err tied to 0, low address bits ignored for half/word
module spm_lsu #(
    parameter logic READ  = 1'b1,
    parameter logic WRITE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    output logic        ready,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic [29:0] spm_addr,
    output logic        spm_as_,
    output logic        spm_rw,
    output logic [31:0] spm_wr_data,
    input  logic [31:0] spm_rd_data
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d, uns_q, uns_d, mis_q, mis_d;
    logic [1:0]  size_q, size_d, off_q, off_d;
    logic [31:0] wdata_q, wdata_d, res_q, res_d;
    logic        ready_q, ready_d, done_q, done_d, err_q, err_d;
    logic        spm_as_q, spm_as_d, spm_rw_q, spm_rw_d;
    logic [31:0] rdata_q, rdata_d, spm_wr_data_q, spm_wr_data_d;
    logic [29:0] spm_addr_q, spm_addr_d;

    logic        mis;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext, merged;

`ifdef SPM_LSU_MISALIGN_CHK_EN
    assign mis = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
`else
    // Without checking, half uses only addr[1] and word ignores addr[1:0].
    assign mis = 1'b0;
`endif

    // Lane extraction and merge, operating on the word returned during RD.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = spm_rd_data[31:24];
            2'd1:    ld_byte = spm_rd_data[23:16];
            2'd2:    ld_byte = spm_rd_data[15:8];
            default: ld_byte = spm_rd_data[7:0];
        endcase
        ld_half = off_q[1] ? spm_rd_data[15:0] : spm_rd_data[31:16];

        if (size_q[1])
            ld_ext = spm_rd_data;
        else if (size_q[0])
            ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
        else
            ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};

        merged = spm_rd_data;
        if (size_q[0]) begin
            if (off_q[1]) merged[15:0]  = wdata_q[15:0];
            else          merged[31:16] = wdata_q[15:0];
        end else begin
            case (off_q)
                2'd0:    merged[31:24] = wdata_q[7:0];
                2'd1:    merged[23:16] = wdata_q[7:0];
                2'd2:    merged[15:8]  = wdata_q[7:0];
                default: merged[7:0]   = wdata_q[7:0];
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        uns_d         = uns_q;
        mis_d         = mis_q;
        size_d        = size_q;
        off_d         = off_q;
        wdata_d       = wdata_q;
        res_d         = res_q;
        spm_addr_d    = spm_addr_q;
        spm_wr_data_d = spm_wr_data_q;

        case (state_q)
            IDLE: if (req) begin
                we_d       = we;
                size_d     = size;
                uns_d      = uns;
                off_d      = addr[1:0];
                wdata_d    = wdata;
                mis_d      = mis;
                res_d      = '0;    // stores and errors report rdata=0
                spm_addr_d = {addr[29:2], 2'b00};
                if (mis) begin
                    state_d = RESP;
                end else if (!we || !size[1]) begin
                    state_d = RD;
                end else begin
                    state_d       = WR;
                    spm_wr_data_d = wdata;
                end
            end
            RD: begin
                if (we_q) begin
                    state_d       = WR;
                    spm_wr_data_d = merged;
                end else begin
                    state_d = RESP;
                    res_d   = ld_ext;
                end
            end
            WR:      state_d = RESP;
            default: state_d = IDLE;
        endcase

        // Port outputs are registered from the next state so they line up
        // with the state they belong to.
        ready_d  = (state_d == IDLE);
        spm_as_d = !(state_d == RD || state_d == WR);
        spm_rw_d = (state_d == WR) ? WRITE : READ;
        // Response flops load while in RESP, so done appears one cycle later.
        done_d   = (state_q == RESP);
        rdata_d  = (state_q == RESP) ? res_q : '0;
        err_d    = (state_q == RESP) && mis_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            uns_q         <= 1'b0;
            mis_q         <= 1'b0;
            size_q        <= 2'b00;
            off_q         <= 2'b00;
            wdata_q       <= '0;
            res_q         <= '0;
            ready_q       <= 1'b1;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            spm_as_q      <= 1'b1;
            spm_rw_q      <= READ;
            spm_addr_q    <= '0;
            spm_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            uns_q         <= uns_d;
            mis_q         <= mis_d;
            size_q        <= size_d;
            off_q         <= off_d;
            wdata_q       <= wdata_d;
            res_q         <= res_d;
            ready_q       <= ready_d;
            done_q        <= done_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
            spm_as_q      <= spm_as_d;
            spm_rw_q      <= spm_rw_d;
            spm_addr_q    <= spm_addr_d;
            spm_wr_data_q <= spm_wr_data_d;
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign err         = err_q;
    assign rdata       = rdata_q;
    assign spm_as_     = spm_as_q;
    assign spm_rw      = spm_rw_q;
    assign spm_addr    = spm_addr_q;
    assign spm_wr_data = spm_wr_data_q;

endmodule

// File: tb/tb_spm_lsu.sv
module tb_spm_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        req, ready, we, uns, done, err, spm_as_, spm_rw;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata, spm_wr_data, spm_rd_data;
    logic [29:0] spm_addr;

    int checks = 0;
    int errors = 0;

    logic [31:0] spm_mem [64];   // SPM environment model (words)
    logic [7:0]  ref_mem [256];  // reference model, byte addressed

    always #5 clk = ~clk;

    spm_lsu dut (
        .clk(clk), .rst(rst), .req(req), .ready(ready), .we(we), .size(size),
        .uns(uns), .addr(addr), .wdata(wdata), .rdata(rdata), .done(done),
        .err(err), .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
        .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data)
    );

    assign spm_rd_data = spm_mem[spm_addr[7:2]];
    always @(posedge clk)
        if (!spm_as_ && spm_rw == 1'b0) spm_mem[spm_addr[7:2]] = spm_wr_data;

    task automatic set_word(input int a, input logic [31:0] w);
        spm_mem[a / 4] = w;
        for (int k = 0; k < 4; k++) ref_mem[(a & ~3) + k] = w[31 - 8 * k -: 8];
    endtask

    // Issues one request and observes it to completion. lat = edges after accept.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic e, output int lat,
                          output int nrd, output int nwr,
                          output logic [31:0] wseen, output logic [29:0] aseen);
        @(negedge clk);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
        @(posedge clk); #1 req = 1'b0;
        lat = -1; nrd = 0; nwr = 0; rd = 'x; e = 1'bx; wseen = 'x; aseen = 'x;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (!spm_as_) begin
                aseen = spm_addr;
                if (spm_rw) nrd++;
                else begin nwr++; wseen = spm_wr_data; end
            end
            if (done) begin lat = i - 1; rd = rdata; e = err; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({ready, done, err, spm_as_, spm_rw} !== 5'b10011 || rdata !== 32'h0 ||
            spm_addr !== 30'h0 || spm_wr_data !== 32'h0) begin
            errors++;
            $display("FAIL reset: ready=%b done=%b err=%b as_=%b rw=%b rdata=%h addr=%h wd=%h required 1 0 0 1 1 0 0 0",
                     ready, done, err, spm_as_, spm_rw, rdata, spm_addr, spm_wr_data);
        end
    endtask

    task automatic test_word_store_load;
        logic [31:0] rd, ws; logic e; int lat, nrd, nwr; logic [29:0] as;
        set_word(32'h10, 32'h0);
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, e, lat, nrd, nwr, ws, as);
        checks++;
        if (lat !== 2 || nrd !== 0 || nwr !== 1 || ws !== 32'hDEADBEEF || as !== 30'h10 || rd !== 32'h0) begin
            errors++;
            $display("FAIL word_store: lat=%0d rd_cyc=%0d wr_cyc=%0d wdata=%h addr=%h rdata=%h required 2 0 1 deadbeef 10 0",
                     lat, nrd, nwr, ws, as, rd);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, e, lat, nrd, nwr, ws, as);
        checks++;
        if (rd !== 32'hDEADBEEF || lat !== 2 || nrd !== 1 || nwr !== 0 || e !== 1'b0) begin
            errors++;
            $display("FAIL word_load: rdata=%h lat=%0d rd_cyc=%0d wr_cyc=%0d err=%b required deadbeef 2 1 0 0",
                     rd, lat, nrd, nwr, e);
        end
    endtask

    task automatic test_byte_loads;
        logic [31:0] rd, ws; logic e; int lat, nrd, nwr; logic [29:0] as;
        set_word(32'h20, 32'h1280FF34);
        do_req(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, rd, e, lat, nrd, nwr, ws, as);
        checks++;
        if (rd !== 32'hFFFFFF80 || lat !== 2) begin
            errors++; $display("FAIL lb_signed: rdata=%h lat=%0d required ffffff80 2", rd, lat);
        end
        do_req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, rd, e, lat, nrd, nwr, ws, as);
        checks++;
        if (rd !== 32'h00000080) begin
            errors++; $display("FAIL lb_unsigned: rdata=%h required 00000080", rd);
        end
        do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd, e, lat, nrd, nwr, ws, as);
        checks++;
        if (rd !== 32'hFFFFFF34) begin
            errors++; $display("FAIL lh_signed: rdata=%h required ffffff34", rd);
        end
        do_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, rd, e, lat, nrd, nwr, ws, as);
        checks++;
        if (rd !== 32'h00001280) begin
            errors++; $display("FAIL lhu_upper: rdata=%h required 00001280", rd);
        end
    endtask

    task automatic test_rmw;
        logic [31:0] rd, ws; logic e; int lat, nrd, nwr; logic [29:0] as;
        set_word(32'h30, 32'h11223344);
        do_req(1'b1, 2'b00, 1'b0, 32'h32, 32'h000000AB, rd, e, lat, nrd, nwr, ws, as);
        checks++;
        if (lat !== 3 || nrd !== 1 || nwr !== 1 || ws !== 32'h1122AB44 || spm_mem[12] !== 32'h1122AB44) begin
            errors++;
            $display("FAIL byte_rmw: lat=%0d rd_cyc=%0d wr_cyc=%0d wdata=%h mem=%h required 3 1 1 1122ab44 1122ab44",
                     lat, nrd, nwr, ws, spm_mem[12]);
        end
        do_req(1'b1, 2'b01, 1'b0, 32'h30, 32'h5555CDEF, rd, e, lat, nrd, nwr, ws, as);
        checks++;
        if (lat !== 3 || ws !== 32'hCDEFAB44) begin
            errors++; $display("FAIL half_rmw: lat=%0d wdata=%h required 3 cdefab44", lat, ws);
        end
    endtask

    task automatic test_misalign;
        logic [31:0] rd, ws; logic e; int lat, nrd, nwr; logic [29:0] as;
        set_word(32'h30, 32'h11223344);
        do_req(1'b0, 2'b01, 1'b0, 32'h31, 32'h0, rd, e, lat, nrd, nwr, ws, as);
        checks++;
`ifdef SPM_LSU_MISALIGN_CHK_EN
        if (e !== 1'b1 || rd !== 32'h0 || lat !== 1 || nrd + nwr !== 0) begin
            errors++;
            $display("FAIL misalign: err=%b rdata=%h lat=%0d acc=%0d required 1 0 1 0", e, rd, lat, nrd + nwr);
        end
`else
        if (e !== 1'b0 || rd !== 32'h00001122 || lat !== 2 || nrd !== 1) begin
            errors++;
            $display("FAIL misalign: err=%b rdata=%h lat=%0d rd_cyc=%0d required 0 1122 2 1", e, rd, lat, nrd);
        end
`endif
    endtask

    task automatic test_busy;
        int pulses = 0; logic [31:0] first = 'x; logic rdy_in_rd;
        set_word(32'h40, 32'hCAFEF00D);
        set_word(32'h44, 32'h01020304);
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h40;
        @(negedge clk);                 // in RD
        rdy_in_rd = ready;
        addr = 32'h44;                  // held req must be ignored
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done) begin pulses++; if (pulses == 1) first = rdata; end
            @(negedge clk);
        end
        checks++;
        if (rdy_in_rd !== 1'b0 || pulses !== 1 || first !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL busy: ready_rd=%b pulses=%0d rdata=%h required 0 1 cafef00d", rdy_in_rd, pulses, first);
        end
    endtask

    task automatic test_reset_mid;
        int pulses = 0; bit seen = 0;
        set_word(32'h30, 32'h11223344);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h33; wdata = 32'h99;
        @(posedge clk); #1 req = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (!spm_as_ && spm_rw == 1'b0) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL reset_mid_wr: WR cycle seen=0 required 1");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (spm_as_ !== 1'b1 || ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_async: as_=%b ready=%b required 1 1", spm_as_, ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0 || spm_mem[12] !== 32'h11223344) begin
            errors++; $display("FAIL reset_mid_abort: done=%0d mem=%h required 0 11223344", pulses, spm_mem[12]);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, ws, ev; logic e, ee, w, u; logic [1:0] sz; int lat, nrd, nwr, elat, nb, ea, a;
        logic [29:0] as; logic [31:0] wd; bit m;
        for (int i = 0; i < 64; i++) set_word(4 * i, $urandom);
        for (int t = 0; t < 60; t++) begin
            w = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3)); u = 1'($urandom_range(0, 1));
            a = $urandom_range(0, 255); wd = $urandom;
            nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            ea = a & ~(nb - 1);
`ifdef SPM_LSU_MISALIGN_CHK_EN
            m = (a != ea);
`else
            m = 0;
`endif
            ev = 32'h0; ee = m;
            if (m) elat = 1;
            else if (!w) begin
                elat = 2;
                for (int k = 0; k < nb; k++) ev = {ev[23:0], ref_mem[ea + k]};
                if (nb < 4 && !u && ref_mem[ea][7]) ev = ev | (32'hFFFFFFFF << (8 * nb));
            end else begin
                elat = (nb == 4) ? 2 : 3;
                for (int k = 0; k < nb; k++) ref_mem[ea + k] = wd[8 * (nb - 1 - k) +: 8];
            end
            do_req(w, sz, u, 32'(a), wd, rd, e, lat, nrd, nwr, ws, as);
            checks++;
            if (rd !== ev || e !== ee || lat !== elat || (m && (nrd + nwr) != 0)) begin
                errors++;
                $display("FAIL random[%0d] we=%b sz=%0d a=%h: rdata=%h err=%b lat=%0d required %h %b %0d",
                         t, w, sz, a, rd, e, lat, ev, ee, elat);
            end
        end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (spm_mem[i] !== {ref_mem[4*i], ref_mem[4*i+1], ref_mem[4*i+2], ref_mem[4*i+3]}) begin
                errors++;
                $display("FAIL mem[%0d]: %h required %h", i, spm_mem[i],
                         {ref_mem[4*i], ref_mem[4*i+1], ref_mem[4*i+2], ref_mem[4*i+3]});
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) set_word(4 * i, 32'h0);
        test_reset;
        test_word_store_load;
        test_byte_loads;
        test_rmw;
        test_misalign;
        test_busy;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
